// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver
//
// Oversamples the asynchronous rx line at CLKS_PER_BIT clocks per bit,
// samples every bit at mid-bit and presents each correctly framed byte on
// `data` with a one-cycle `valid` strobe. A stop bit sampled low produces a
// one-cycle `frame_err` strobe instead and leaves `data` untouched.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (even, >= 4)
//   CNT_W        : bit-timing counter width (derived, do not override)
//
// Ports
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   rx        in   serial line, asynchronous to clock, idle high
//   data      out  last correctly framed byte, held until the next one
//   valid     out  one-cycle pulse when data has just been updated
//   frame_err out  one-cycle pulse when the stop bit was sampled low
//   busy      out  high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  // Compare points for the bit-timing counter: mid start bit and full bit.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning: two-flop synchronizer plus one history flop for the
  // falling-edge detector.
  // --------------------------------------------------------------------------
  logic rx_m;
  logic rx_s;
  logic rx_d;
  logic start_edge;

  // Reset to 1 so that the released line looks idle and no false start edge
  // appears on the first cycles after reset.
  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge value of its source and the order of statements does not matter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // A 1->0 transition is required; a line stuck low never retriggers.
  assign start_edge = !rx_s && rx_d;

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic [7:0]       data_next;
  logic             valid_next;
  logic             frame_err_next;
  logic             busy_next;

  // NOTE: every signal driven here is given a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt + 1'b1;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    data_next      = data;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start_edge) begin
          state_next = START;
        end
      end

      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt == HALF_M1) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        // Counter was realigned at mid start bit, so each full count lands
        // at the middle of the next data bit. LSB arrives first.
        if (cnt == BIT_M1) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end

      STOP: begin
        // Leave at mid stop bit so a start bit immediately following the
        // stop bit is caught; back-to-back frames need no idle gap.
        if (cnt == BIT_M1) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rx_s) begin
            data_next  = shift;
            valid_next = 1'b1;
          end else begin
            frame_err_next = 1'b1;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy_next = (state_next != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      data      <= data_next;
      valid     <= valid_next;
      frame_err <= frame_err_next;
      busy      <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx (CLKS_PER_BIT = 16).
// Stimulus pushes the expected outcome of each frame into a scoreboard queue;
// an independent monitor pops and compares on every valid/frame_err pulse.
// Bit durations are given in half clock cycles so that skewed baud rates
// (15.5 / 16.5 clocks per bit) can be produced with integer arithmetic.
// ----------------------------------------------------------------------------
module tb_uart_rx;

  typedef struct {
    logic       is_err;
    logic [7:0] byte_v;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int   n_tests;
  int   n_fail;
  int   cyc;
  int   fall_cyc;
  logic [7:0] last_good;
  exp_t sb_q[$];
  int   valid_cycs[$];

  uart_rx #(.CLKS_PER_BIT(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output strobe must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && (valid || frame_err)) begin
      check("valid_frame_err_exclusive", {31'd0, valid & frame_err}, 32'd0);
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b data=%0h expected no pulse",
                 valid, frame_err, data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_kind_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
        check("pulse_data", {24'd0, data}, {24'd0, e.byte_v});
      end
      if (valid) valid_cycs.push_back(cyc);
    end
  end

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // hb = half clock cycles per bit (32 = nominal 16 clocks per bit).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hb,
                            input logic expect_it);
    logic [9:0] bits;
    int dur;
    bits = {stop, b, 1'b0};
    if (expect_it) begin
      if (stop) begin
        sb_q.push_back('{is_err: 1'b0, byte_v: b});
        last_good = b;
      end else begin
        sb_q.push_back('{is_err: 1'b1, byte_v: last_good});
      end
    end
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rx  = bits[i];
      dur = ((i + 1) * hb) / 2 - (i * hb) / 2;
      repeat (dur) @(posedge clock);
      #1;
    end
  endtask

  // Watchdog so the bench always ends on its own.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    n_tests   = 0;
    n_fail    = 0;
    last_good = 8'h00;
    rx        = 1'b1;
    reset_n   = 1'b0;

    // 1. Reset state, single frame, latency.
    repeat (5) @(posedge clock);
    #1;
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    idle(5);
    send_frame(8'h40, 1'b1, 32, 1'b1);
    idle(4);
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_valid_count", valid_cycs.size(), 32'd1);
    if (valid_cycs.size() >= 1)
      check("t1_latency", valid_cycs[valid_cycs.size() - 1] - fall_cyc, 32'd155);

    // 2. Back-to-back frames, no idle gap.
    n0 = valid_cycs.size();
    send_frame(8'hA5, 1'b1, 32, 1'b1);
    send_frame(8'h3C, 1'b1, 32, 1'b1);
    idle(4);
    check("t2_valid_count", valid_cycs.size() - n0, 32'd2);
    if (valid_cycs.size() - n0 == 2)
      check("t2_spacing", valid_cycs[n0 + 1] - valid_cycs[n0], 32'd160);
    check("t2_data_last", {24'd0, data}, 32'h3C);

    // 3. Three-cycle glitch: false start rejected at mid start bit.
    idle(10);
    rx = 1'b0;
    fall_cyc = cyc;
    repeat (3) @(posedge clock);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("t3_busy_during", {31'd0, busy}, 32'd1);
    repeat (7) @(posedge clock);
    #1;
    check("t3_busy_by_t0p9", {31'd0, busy}, 32'd0);
    idle(20);
    send_frame(8'h81, 1'b1, 32, 1'b1);
    idle(4);
    check("t3_data", {24'd0, data}, 32'h81);

    // 4. Framing error, line held low, then recovery.
    idle(10);
    send_frame(8'h55, 1'b0, 32, 1'b1);
    rx = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    check("t4_busy_while_low", {31'd0, busy}, 32'd0);
    check("t4_data_held", {24'd0, data}, {24'd0, last_good});
    check("t4_sb_drained", sb_q.size(), 32'd0);
    idle(20);
    send_frame(8'h0F, 1'b1, 32, 1'b1);
    idle(4);
    check("t4_data_recover", {24'd0, data}, 32'h0F);

    // 5. Reset in the middle of data bit 4 of 8'hFF.
    idle(10);
    n0 = valid_cycs.size();
    fork
      send_frame(8'hFF, 1'b1, 32, 1'b0);
      begin
        repeat (88) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_reset_data", {24'd0, data}, 32'h00);
        check("t5_reset_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
      end
    join
    idle(20);
    check("t5_no_valid", valid_cycs.size() - n0, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_data_zero", {24'd0, data}, 32'h00);
    last_good = 8'h00;
    send_frame(8'h12, 1'b1, 32, 1'b1);
    idle(4);
    check("t5_data_next", {24'd0, data}, 32'h12);

    // 6. Baud skew: 15.5 and 16.5 clocks per bit.
    idle(10);
    send_frame(8'hC3, 1'b1, 31, 1'b1);
    idle(10);
    check("t6_fast_data", {24'd0, data}, 32'hC3);
    send_frame(8'h3C, 1'b1, 32, 1'b1);
    idle(10);
    send_frame(8'hC3, 1'b1, 33, 1'b1);
    idle(10);
    check("t6_slow_data", {24'd0, data}, 32'hC3);

    // Drain: all expected pulses must have been observed.
    for (int i = 0; i < 500 && sb_q.size() != 0; i++) begin
      @(posedge clock);
      #1;
    end
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
